dual_rail_receiver: RTL and testbench

- Receive end of the two-wire symbol link driven by the Sender block (Bit0_Out/Bit1_Out/ack).
- Performs the four-phase handshake: data line high -> ack high -> data line low -> ack low.
- Assembles symbols into 10-symbol command frames and presents the decoded channel and direction to downstream control logic.
- Flags malformed frames and timeouts.

---
 rtl/dual_rail_receiver.sv | 247 ++++++++++++++++++++++++
 tb/tb_dual_rail_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_rail_receiver.sv
// dual_rail_receiver
//   Receive end of the two-wire (dual-rail) symbol link. Each symbol arrives
//   as a rising edge on bit0_in ('0') or bit1_in ('1'). The block completes a
//   four-phase handshake with ack, assembles ten symbols into a command frame
//   and presents the decoded channel and direction.
//
//   Frame layout (index 0..9): SOF 1,1,0 | CH | SEP 0,1 | DIR | EOF 1,0,0
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   bit0_in      asynchronous data rail for symbol '0'
//   bit1_in      asynchronous data rail for symbol '1'
//   ack          registered handshake acknowledge to the sender
//   frame_valid  one-cycle pulse, complete legal frame received
//   ch_out       decoded channel (0 = Ch1, 1 = Ch2), held until next frame
//   dir_out      decoded direction (0 = Down, 1 = Up), held until next frame
//   frame_err    one-cycle pulse, illegal symbol, bad pattern or timeout
//   busy         high while a frame is in progress or ack is high
//   frame_count  count of valid frames, wraps 255 -> 0
module dual_rail_receiver #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TCNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit0_in,
  input  logic       bit1_in,
  output logic       ack,
  output logic       frame_valid,
  output logic       ch_out,
  output logic       dir_out,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_count
);

  typedef enum logic [0:0] {
    WAIT_DATA = 1'b0,
    WAIT_RTZ  = 1'b1
  } hs_state_t;

  // Expected symbol for a frame position: {checked, value}. CH and DIR
  // positions are unchecked payload.
  function automatic logic [1:0] pattern_bit(input logic [3:0] idx);
    logic [1:0] res;
    case (idx)
      4'd0:    res = 2'b11;
      4'd1:    res = 2'b11;
      4'd2:    res = 2'b10;
      4'd3:    res = 2'b00;
      4'd4:    res = 2'b10;
      4'd5:    res = 2'b11;
      4'd6:    res = 2'b00;
      4'd7:    res = 2'b11;
      4'd8:    res = 2'b10;
      4'd9:    res = 2'b10;
      default: res = 2'b10;
    endcase
    return res;
  endfunction

  logic              b0_meta_r, b1_meta_r;
  logic              s0_r, s1_r;
  hs_state_t         state_r;
  logic              ack_r;
  logic [3:0]        idx_r;
  logic              ch_shadow_r, dir_shadow_r;
  logic              ch_r, dir_r;
  logic [7:0]        count_r;
  logic              valid_r, err_r, busy_r;
  logic [TCNT_W-1:0] tcnt_r;
  logic              tfired_r;

  logic              hs_take_s, hs_ill_s, hs_rtz_s, hs_chg_s;
  logic              ack_nxt_s;
  logic [1:0]        exp_s;
  logic [3:0]        idx_nxt_s;
  logic              ch_shadow_nxt_s, dir_shadow_nxt_s;
  logic              ch_nxt_s, dir_nxt_s;
  logic [7:0]        count_nxt_s;
  logic              valid_nxt_s, err_nxt_s;
  logic [TCNT_W-1:0] tcnt_nxt_s;
  logic              tfired_nxt_s;

  // Two-flop synchronisers for the asynchronous rail inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      b0_meta_r <= 1'b0;
      b1_meta_r <= 1'b0;
      s0_r      <= 1'b0;
      s1_r      <= 1'b0;
    end else begin
      b0_meta_r <= bit0_in;
      b1_meta_r <= bit1_in;
      s0_r      <= b0_meta_r;
      s1_r      <= b1_meta_r;
    end
  end

  // Handshake events decoded from the synchronised rails.
  always_comb begin
    hs_take_s = (state_r == WAIT_DATA) && (s0_r ^ s1_r);
    hs_ill_s  = (state_r == WAIT_DATA) && s0_r && s1_r;
    hs_rtz_s  = (state_r == WAIT_RTZ) && !s0_r && !s1_r;
    hs_chg_s  = hs_take_s || hs_ill_s || hs_rtz_s;
    if (hs_take_s || hs_ill_s) begin
      ack_nxt_s = 1'b1;
    end else if (hs_rtz_s) begin
      ack_nxt_s = 1'b0;
    end else begin
      ack_nxt_s = ack_r;
    end
  end

  // Handshake state machine; an illegal symbol is still acknowledged so the
  // sender can always return to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= WAIT_DATA;
      ack_r   <= 1'b0;
    end else begin
      case (state_r)
        WAIT_DATA: begin
          if (s0_r || s1_r) begin
            state_r <= WAIT_RTZ;
            ack_r   <= 1'b1;
          end
        end
        WAIT_RTZ: begin
          if (!s0_r && !s1_r) begin
            state_r <= WAIT_DATA;
            ack_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= WAIT_DATA;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Frame assembly, pattern checking and stall timeout.
  always_comb begin
    idx_nxt_s        = idx_r;
    ch_shadow_nxt_s  = ch_shadow_r;
    dir_shadow_nxt_s = dir_shadow_r;
    ch_nxt_s         = ch_r;
    dir_nxt_s        = dir_r;
    count_nxt_s      = count_r;
    valid_nxt_s      = 1'b0;
    err_nxt_s        = 1'b0;
    tcnt_nxt_s       = tcnt_r;
    tfired_nxt_s     = tfired_r;
    exp_s            = pattern_bit(idx_r);

    if (hs_ill_s) begin
      err_nxt_s = 1'b1;
      idx_nxt_s = 4'd0;
    end else if (hs_take_s) begin
      if (!exp_s[1]) begin
        if (idx_r == 4'd3) begin
          ch_shadow_nxt_s = s1_r;
        end else begin
          dir_shadow_nxt_s = s1_r;
        end
        idx_nxt_s = idx_r + 4'd1;
      end else if (s1_r == exp_s[0]) begin
        if (idx_r == 4'd9) begin
          ch_nxt_s    = ch_shadow_r;
          dir_nxt_s   = dir_shadow_r;
          count_nxt_s = count_r + 8'd1;
          valid_nxt_s = 1'b1;
          idx_nxt_s   = 4'd0;
        end else begin
          idx_nxt_s = idx_r + 4'd1;
        end
      end else if (idx_r < 4'd3) begin
        // SOF hunting: a '1' can only mismatch at position 2, and then the
        // last two symbols (1,1) already form a two-symbol SOF prefix.
        idx_nxt_s = s1_r ? 4'd2 : 4'd0;
      end else begin
        err_nxt_s = 1'b1;
        idx_nxt_s = 4'd0;
      end
    end else begin
      idx_nxt_s = idx_r;
    end

    // tfired_r limits a stall to a single timeout error until the next
    // handshake event.
    if (hs_chg_s) begin
      tcnt_nxt_s   = {TCNT_W{1'b0}};
      tfired_nxt_s = 1'b0;
    end else if (((idx_r != 4'd0) || (state_r == WAIT_RTZ)) && !tfired_r) begin
      if (tcnt_r == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_nxt_s    = 1'b1;
        idx_nxt_s    = 4'd0;
        tcnt_nxt_s   = {TCNT_W{1'b0}};
        tfired_nxt_s = 1'b1;
      end else begin
        tcnt_nxt_s = tcnt_r + TCNT_W'(1);
      end
    end else begin
      tcnt_nxt_s = tcnt_r;
    end
  end

  // Frame state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r        <= 4'd0;
      ch_shadow_r  <= 1'b0;
      dir_shadow_r <= 1'b0;
      ch_r         <= 1'b0;
      dir_r        <= 1'b0;
      count_r      <= 8'd0;
      valid_r      <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      tcnt_r       <= {TCNT_W{1'b0}};
      tfired_r     <= 1'b0;
    end else begin
      idx_r        <= idx_nxt_s;
      ch_shadow_r  <= ch_shadow_nxt_s;
      dir_shadow_r <= dir_shadow_nxt_s;
      ch_r         <= ch_nxt_s;
      dir_r        <= dir_nxt_s;
      count_r      <= count_nxt_s;
      valid_r      <= valid_nxt_s;
      err_r        <= err_nxt_s;
      busy_r       <= (idx_nxt_s != 4'd0) || ack_nxt_s;
      tcnt_r       <= tcnt_nxt_s;
      tfired_r     <= tfired_nxt_s;
    end
  end

  assign ack         = ack_r;
  assign frame_valid = valid_r;
  assign ch_out      = ch_r;
  assign dir_out     = dir_r;
  assign frame_err   = err_r;
  assign busy        = busy_r;
  assign frame_count = count_r;

endmodule

// File: tb/tb_dual_rail_receiver.sv
module tb_dual_rail_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit0_in;
  logic       bit1_in;
  logic       ack;
  logic       frame_valid;
  logic       ch_out;
  logic       dir_out;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_count;

  int tests  = 0;
  int failed = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int rise_lat;
  int fall_lat;
  logic valid_at_rise;
  int v0, e0, ack_drop, n;
  logic [7:0] ib;
  logic [9:0] fr;

  always #5 clk = ~clk;

  dual_rail_receiver #(
    .TIMEOUT_CYCLES(20),
    .TCNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bit0_in(bit0_in),
    .bit1_in(bit1_in),
    .ack(ack),
    .frame_valid(frame_valid),
    .ch_out(ch_out),
    .dir_out(dir_out),
    .frame_err(frame_err),
    .busy(busy),
    .frame_count(frame_count)
  );

  // Pulse monitor: counts output pulses seen at each rising edge.
  always @(posedge clk) begin
    if (frame_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
    if (frame_valid === 1'b1 && frame_err === 1'b1) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One four-phase handshake as the sender performs it.
  task automatic send_sym(input logic v, input logic both);
    @(negedge clk);
    if (both) begin
      bit0_in = 1'b1;
      bit1_in = 1'b1;
    end else begin
      bit0_in = ~v;
      bit1_in = v;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 40);
    rise_lat = n;
    valid_at_rise = frame_valid;
    check("ack_rise", ack, 1);
    bit0_in = 1'b0;
    bit1_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b0 && n < 40);
    fall_lat = n;
    check("ack_fall", ack, 0);
  endtask

  task automatic send_seq(input logic [15:0] bits, input int len, input logic chk_lat);
    for (int k = len - 1; k >= 0; k--) begin
      send_sym(bits[k], 1'b0);
      if (chk_lat) begin
        check("rise_latency", rise_lat, 3);
        check("fall_latency", fall_lat, 3);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    bit0_in = 1'b0;
    bit1_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ch", ch_out, 0);
    check("rst_dir", dir_out, 0);
    check("rst_count", frame_count, 0);
    reset = 1'b0;

    // Basic frame: CH=1, DIR=1, with latency checks on every symbol.
    v0 = n_valid; e0 = n_err;
    send_seq(16'b1101011100, 10, 1'b1);
    check("t1_valid_with_ack", valid_at_rise, 1);
    check("t1_valid_cnt", n_valid - v0, 1);
    check("t1_err_cnt", n_err - e0, 0);
    check("t1_ch", ch_out, 1);
    check("t1_dir", dir_out, 1);
    check("t1_count", frame_count, 1);
    check("t1_busy", busy, 0);

    // SOF hunting: extra leading '1'.
    v0 = n_valid; e0 = n_err;
    send_seq(16'b11100010100, 11, 1'b0);
    check("t2_valid_cnt", n_valid - v0, 1);
    check("t2_err_cnt", n_err - e0, 0);
    check("t2_ch", ch_out, 0);
    check("t2_dir", dir_out, 0);
    check("t2_count", frame_count, 2);

    // Illegal symbol at index 4, then a good frame.
    v0 = n_valid; e0 = n_err;
    send_seq(16'b1101, 4, 1'b0);
    send_sym(1'b0, 1'b1);
    check("t3_err_cnt", n_err - e0, 1);
    check("t3_busy", busy, 0);
    check("t3_ch_kept", ch_out, 0);
    send_seq(16'b1100011100, 10, 1'b0);
    check("t3_valid_cnt", n_valid - v0, 1);
    check("t3_err_total", n_err - e0, 1);
    check("t3_ch", ch_out, 0);
    check("t3_dir", dir_out, 1);
    check("t3_count", frame_count, 3);

    // Idle timeout mid-frame: error 20 cycles after the last ack fall.
    e0 = n_err;
    send_seq(16'b1101, 4, 1'b0);
    repeat (19) @(negedge clk);
    check("t4_err_early", frame_err, 0);
    check("t4_busy_early", busy, 1);
    @(negedge clk);
    check("t4_err_pulse", frame_err, 1);
    check("t4_busy_drop", busy, 0);
    @(negedge clk);
    check("t4_err_single", frame_err, 0);
    check("t4_err_cnt", n_err - e0, 1);

    // Rail held high for 25 cycles mid-frame: one timeout, ack stays high.
    send_seq(16'b11, 2, 1'b0);
    @(negedge clk);
    bit0_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 40);
    check("t4h_ack_rise", ack, 1);
    e0 = n_err;
    ack_drop = 0;
    repeat (22) begin
      @(negedge clk);
      if (ack !== 1'b1) ack_drop++;
    end
    check("t4h_ack_held", ack_drop, 0);
    check("t4h_err_cnt", n_err - e0, 1);
    bit0_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b0 && n < 40);
    check("t4h_ack_fall", ack, 0);
    check("t4h_err_once", n_err - e0, 1);
    check("t4h_busy", busy, 0);

    // Reset during the DIR handshake.
    send_seq(16'b110101, 6, 1'b0);
    check("t5_busy_pre", busy, 1);
    @(negedge clk);
    bit1_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 40);
    check("t5_ack_pre", ack, 1);
    reset   = 1'b1;
    bit1_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_ack", ack, 0);
    check("t5_busy", busy, 0);
    check("t5_ch", ch_out, 0);
    check("t5_dir", dir_out, 0);
    check("t5_count", frame_count, 0);
    v0 = n_valid;
    send_seq(16'b1101010100, 10, 1'b0);
    check("t5_valid_cnt", n_valid - v0, 1);
    check("t5_ch_after", ch_out, 1);
    check("t5_dir_after", dir_out, 0);
    check("t5_count_after", frame_count, 1);

    // 256 frames from a clean count: wraps back to zero.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_count_start", frame_count, 0);
    v0 = n_valid;
    for (int i = 0; i < 255; i++) begin
      ib = i[7:0];
      fr = {3'b110, ib[0], 2'b01, ib[1], 3'b100};
      send_seq({6'd0, fr}, 10, 1'b0);
    end
    check("t6_count_255", frame_count, 255);
    check("t6_ch_254", ch_out, 0);
    check("t6_dir_254", dir_out, 1);
    send_seq(16'b1101011100, 10, 1'b0);
    check("t6_count_wrap", frame_count, 0);
    check("t6_ch_last", ch_out, 1);
    check("t6_dir_last", dir_out, 1);
    check("t6_valid_cnt", n_valid - v0, 256);

    check("never_valid_and_err", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
